onehot_index_decoder: RTL and testbench
=======================================

// Module: onehot_index_decoder
// PURPOSE
//  Inverse of the priority-encoder stage: converts a one-hot grant vector back to a binary index.
//  Sits downstream of the encoder and feeds the index to consumers through a valid/ready stream.
//  Behaviour on illegal input:
//  - Input with no bit set is flagged as zero.
//  - Input with more than one bit set is flagged as an error and decoded to the highest set bit,
//    which matches encoder priority.
//  A 2-entry skid buffer lets in_ready be driven from registers only, with no combinational
//  path from out_ready.
// PARAMETERS
//  wordLen  8                  width of one-hot input vector (>=2)
//  idxLen   $clog2(wordLen)    width of decoded index (derived, do not override)
//  cntLen   16                 width of decoded-word counter
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        input word valid
//  in_ready   out  1        block can accept a word this cycle
//  in_onehot  in   wordLen  grant vector to decode
//  out_valid  out  1        out_idx/out_zero/out_err valid
//  out_ready  in   1        consumer accepts output this cycle
//  out_idx    out  idxLen   index of highest set bit of accepted word (0 if none)
//  out_zero   out  1        accepted word had no bit set
//  out_err    out  1        accepted word had >1 bit set
//  err_sticky out  1        latched: any error word accepted since last clear
//  err_clr    in   1        clears err_sticky
//  dec_count  out  cntLen   number of output handshakes since reset, saturating
// BEHAVIOUR
//  Reset (rst=1 at a rising edge):
//  - Buffer empties.
//  - out_valid, out_idx, out_zero, out_err, err_sticky and dec_count all go to 0.
//  - in_ready is 0 while rst is high and 1 on the first cycle after reset.
//  - Reset mid-transfer discards any buffered words without producing an output handshake.
//  Handshakes:
//  - Accept when in_valid & in_ready.
//  - Output handshake when out_valid & out_ready.
//  - in_ready = (occupancy < 2). It depends only on registered state, never on out_ready.
//  Decode:
//  - Done combinationally on in_onehot. Result {idx, zero, err} is stored in the buffer at accept.
//  - idx = highest i with in_onehot[i]=1, else 0.
//  - zero = (in_onehot == 0).
//  - err = (popcount > 1).
//  Latency: a word accepted at edge N appears on the outputs with out_valid=1 from edge N onward,
//  i.e. 1 cycle after in_valid is sampled.
//  Occupancy FSM:
//  - EMPTY: accept -> ONE; otherwise stay.
//  - ONE:
//    - accept & pop -> ONE (new word presented);
//    - accept only -> TWO;
//    - pop only -> EMPTY.
//  - TWO: in_ready=0.
//    - pop -> ONE, and the second entry moves to the head;
//    - otherwise stay.
//  Ordering: strict FIFO order; words are never dropped or duplicated.
//  Output stability: while out_valid & ~out_ready, out_idx, out_zero and out_err hold stable.
//  out_valid = (state != EMPTY).
//  dec_count: +1 on each output handshake, saturating at 2^cntLen-1 with no wrap.
//  err_sticky:
//  - Set at an accept with err=1.
//  - Cleared by err_clr.
//  - Set and clear in the same cycle: set wins.
//  - Zero words do not set it.
//  Input while in_ready=0 is ignored; in_onehot is a don't-care when in_valid=0.
// TESTING
//  1. Single word: rst, then in_onehot=8'b0010_0000 with out_ready=1 -> next cycle out_valid=1,
//     out_idx=5, zero=0, err=0; dec_count=1.
//  2. Back-pressure: out_ready=0, push 8'h01, 8'h80, 8'h04 -> first two accepted, in_ready=0 on
//     third. Raise out_ready -> outputs idx 0,7,2 in order; dec_count=3.
//  3. Illegal words: push 8'h00 -> idx=0, zero=1, err_sticky=0. Push 8'h41 -> idx=6, err=1,
//     err_sticky=1. err_clr with simultaneous error word -> err_sticky stays 1.
//  4. Full throughput: in_valid=1 and out_ready=1 for 100 cycles with random one-hot words ->
//     one output per cycle, order preserved, in_ready never drops.
//  5. Reset mid-operation: buffer in TWO, assert rst for 1 cycle -> out_valid=0, dec_count=0, no
//     stale word ever emitted.
//  6. Saturation (cntLen=4): 20 handshakes -> dec_count stops at 15.

Source files
------------

// File: rtl/onehot_index_decoder.sv
// onehot_index_decoder
//   Converts a one-hot grant vector back into a binary index and passes the
//   result downstream over a valid/ready stream. A two-entry skid buffer sits
//   between the decoder and the output. Because of it, in_ready comes from
//   registered state and has no combinational path from out_ready.
//
//   Illegal words are still decoded:
//     - An all-zero word gives index 0 and sets out_zero.
//     - A word with several bits set gives the index of the highest set bit,
//       which matches the upstream encoder's priority, and sets out_err.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input word valid
//   in_ready   block can accept a word this cycle
//   in_onehot  grant vector to decode
//   out_valid  out_idx/out_zero/out_err are valid
//   out_ready  consumer accepts the output this cycle
//   out_idx    index of the highest set bit of the word (0 if none)
//   out_zero   word had no bit set
//   out_err    word had more than one bit set
//   err_sticky latched: an error word was accepted since the last clear
//   err_clr    clears err_sticky (a simultaneous error accept wins)
//   dec_count  saturating count of output handshakes since reset

module onehot_index_decoder #(
  parameter int wordLen = 8,
  parameter int idxLen  = $clog2(wordLen),
  parameter int cntLen  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [wordLen-1:0] in_onehot,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [idxLen-1:0]  out_idx,
  output logic               out_zero,
  output logic               out_err,
  output logic               err_sticky,
  input  logic               err_clr,
  output logic [cntLen-1:0]  dec_count
);

  localparam int popLen = $clog2(wordLen + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occState_e;

  occState_e         state_q;
  logic [idxLen-1:0] headIdx_q;
  logic              headZero_q;
  logic              headErr_q;
  logic [idxLen-1:0] tailIdx_q;
  logic              tailZero_q;
  logic              tailErr_q;
  logic              errSticky_q;
  logic [cntLen-1:0] decCount_q;

  logic [idxLen-1:0] decIdx;
  logic [popLen-1:0] decPop;
  logic              decZero;
  logic              decErr;
  logic              accept;
  logic              pop;

  // Decode the incoming word. The loop runs upward, so the last set bit it
  // sees is the highest one. The same pass counts the set bits for the
  // error flag.
  always_comb begin
    decIdx = '0;
    decPop = '0;
    for (int i = 0; i < wordLen; i++) begin
      if (in_onehot[i]) begin
        decIdx = idxLen'(i);
        decPop = decPop + popLen'(1);
      end
    end
    decZero = (in_onehot == '0);
    decErr  = (decPop > popLen'(1));
  end

  // Ready depends only on the occupancy register. Reset also holds it low,
  // so the block accepts nothing until reset has been released.
  assign in_ready  = ~rst & (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_idx    = headIdx_q;
  assign out_zero   = headZero_q;
  assign out_err    = headErr_q;
  assign err_sticky = errSticky_q;
  assign dec_count  = decCount_q;

  // Occupancy FSM and buffer storage.
  // The head entry always drives the outputs, so it stays stable while the
  // consumer stalls. The tail entry is filled only when the head is busy and
  // is not being popped. It moves to the head when the head drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      headIdx_q  <= '0;
      headZero_q <= 1'b0;
      headErr_q  <= 1'b0;
      tailIdx_q  <= '0;
      tailZero_q <= 1'b0;
      tailErr_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            headIdx_q  <= decIdx;
            headZero_q <= decZero;
            headErr_q  <= decErr;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            headIdx_q  <= decIdx;
            headZero_q <= decZero;
            headErr_q  <= decErr;
          end else if (accept) begin
            tailIdx_q  <= decIdx;
            tailZero_q <= decZero;
            tailErr_q  <= decErr;
            state_q    <= TWO;
          end else if (pop) begin
            state_q    <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            headIdx_q  <= tailIdx_q;
            headZero_q <= tailZero_q;
            headErr_q  <= tailErr_q;
            state_q    <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Sticky error flag. When an error word is accepted in the same cycle as a
  // clear request, the set wins, so that error is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      errSticky_q <= 1'b0;
    end else if (accept && decErr) begin
      errSticky_q <= 1'b1;
    end else if (err_clr) begin
      errSticky_q <= 1'b0;
    end
  end

  // Handshake counter. It stops at all-ones and does not wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      decCount_q <= '0;
    end else if (pop && (decCount_q != {cntLen{1'b1}})) begin
      decCount_q <= decCount_q + cntLen'(1);
    end
  end

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Testbench for onehot_index_decoder.
// The DUT is built with a 4-bit counter so that counter saturation is reached
// quickly. A queue-based reference model tracks the words that are in flight.
// The monitor checks the DUT against that model on every falling edge.

module tb_onehot_index_decoder;

  localparam int WL    = 8;
  localparam int IL    = 3;
  localparam int CL    = 4;
  localparam int CMAX  = (1 << CL) - 1;

  typedef struct packed {
    logic [IL-1:0] idx;
    logic          zero;
    logic          err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_onehot;
  logic          out_valid;
  logic          out_ready;
  logic [IL-1:0] out_idx;
  logic          out_zero;
  logic          out_err;
  logic          err_sticky;
  logic          err_clr;
  logic [CL-1:0] dec_count;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   modelCount = 0;
  bit   modelSticky = 1'b0;

  onehot_index_decoder #(
    .wordLen(WL),
    .cntLen (CL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .err_sticky(err_sticky),
    .err_clr   (err_clr),
    .dec_count (dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode, taken straight from the word's arithmetic meaning.
  // The highest set bit of w is clog2(w+1)-1.
  function automatic exp_t refModel(input logic [WL-1:0] w);
    exp_t r;
    r.zero = (w == '0);
    r.err  = ($countones(w) > 1);
    if (w == '0) r.idx = '0;
    else         r.idx = IL'($clog2(int'(w) + 1) - 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge. The values are held
  // through the next rising edge.
  task automatic applyStimulus(input logic v, input logic [WL-1:0] w,
                               input logic ordy, input logic clr);
    in_valid  = v;
    in_onehot = w;
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WL-1:0] randWord();
    case ($urandom_range(3))
      0:       return '0;
      1:       return WL'($urandom);
      default: return WL'(1) << $urandom_range(WL - 1);
    endcase
  endfunction

  // Monitor and scoreboard. All decisions here use the model's own view of
  // occupancy, never the DUT's handshake outputs.
  always @(negedge clk) begin : monitor
    bit   mReady;
    bit   mValid;
    bit   acc;
    bit   hs;
    exp_t e;
    mReady = !rst && (expQ.size() < 2);
    mValid = (expQ.size() != 0);
    checkOutput("in_ready", int'(in_ready), int'(mReady));
    checkOutput("out_valid", int'(out_valid), int'(mValid));
    checkOutput("err_sticky", int'(err_sticky), int'(modelSticky));
    checkOutput("dec_count", int'(dec_count), modelCount);
    if (mValid && out_valid) begin
      checkOutput("out_idx", int'(out_idx), int'(expQ[0].idx));
      checkOutput("out_zero", int'(out_zero), int'(expQ[0].zero));
      checkOutput("out_err", int'(out_err), int'(expQ[0].err));
    end
    acc = in_valid && mReady;
    hs  = mValid && out_ready;
    if (rst) begin
      expQ.delete();
      modelCount  = 0;
      modelSticky = 1'b0;
    end else begin
      if (hs) begin
        void'(expQ.pop_front());
        if (modelCount < CMAX) modelCount++;
      end
      e = refModel(in_onehot);
      if (acc) expQ.push_back(e);
      if (acc && e.err) modelSticky = 1'b1;
      else if (err_clr) modelSticky = 1'b0;
    end
  end

  initial begin
    int drainCycles;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_onehot = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single word");
    applyStimulus(1'b1, 8'b0010_0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] illegal words");
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] full throughput");
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, WL'(1) << $urandom_range(WL - 1), 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(1)), randWord(),
                    1'($urandom_range(3) != 0), 1'($urandom_range(7) == 0));

    drainCycles = 0;
    while (out_valid && drainCycles < 20) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      drainCycles++;
    end
    checkOutput("drain_timeout", int'(out_valid), 0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
